// File: rtl/riscv_imem_port_if.sv
// Fetch handshake bundle between the core's fetch stage (master) and riscv_imem_port (slave).
interface riscv_imem_port_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic [1:0]        fetch_err;
    logic [31:0]       fetch_count;

    modport master (
        output fetch_req,
        output fetch_addr,
        input  fetch_ready,
        input  fetch_valid,
        input  fetch_data,
        input  fetch_err,
        input  fetch_count
    );

    modport slave (
        input  fetch_req,
        input  fetch_addr,
        output fetch_ready,
        output fetch_valid,
        output fetch_data,
        output fetch_err,
        output fetch_count
    );
endinterface

// File: rtl/riscv_imem_port.sv
// Instruction-memory port: request/valid fetch with programmable wait states,
// bench-side load port and misaligned / out-of-range error reporting.
module riscv_imem_port #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 1024,
    parameter int                WAIT_STATES = 1,
    parameter logic [DATA_W-1:0] OOR_DATA    = 32'h0000_0013
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [DATA_W-1:0]        load_data,
    riscv_imem_port_if.slave         fetch
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] data_q;
    logic [1:0]        err_q;
    logic [31:0]       count_q;

    logic              ready;
    logic              accept;
    logic              misaligned;
    logic              out_of_range;
    logic [1:0]        err_d;
    logic [IDX_W-1:0]  word_idx;

    assign ready        = (state_q == IDLE || state_q == RESP) && !load_en && reset_n;
    assign accept       = fetch.fetch_req && ready;
    assign word_idx     = fetch.fetch_addr[IDX_W+1:2];
    assign misaligned   = fetch.fetch_addr[1:0] != 2'b00;
    // Any set bit above the word-index field addresses beyond DEPTH.
    assign out_of_range = (fetch.fetch_addr >> (IDX_W + 2)) != '0;

    always_comb begin
        err_d = 2'd0;
        if (misaligned) begin
            err_d = 2'd1;
        end else if (out_of_range) begin
            err_d = 2'd2;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                        wcnt_d  = 4'(WAIT_STATES - 1);
                    end else begin
                        state_d = RESP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (wcnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                wcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            data_q  <= '0;
            err_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (accept) begin
                err_q  <= err_d;
                data_q <= (err_d == 2'd0) ? mem[word_idx] : OOR_DATA;
            end
            if (state_q == RESP) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    // Array is deliberately not reset; the environment preloads it.
    always_ff @(posedge clock) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    assign fetch.fetch_ready = ready;
    assign fetch.fetch_valid = state_q == RESP;
    assign fetch.fetch_data  = data_q;
    assign fetch.fetch_err   = err_q;
    assign fetch.fetch_count = count_q;
endmodule

// File: tb/tb_riscv_imem_port.sv
// Bench for riscv_imem_port: three instances (0, 3 and 2 wait states) share load/reset
// stimulus, each checked every cycle against a timeline model plus directed vectors.
module tb_riscv_imem_port;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          BOUND = 40;

    typedef struct {
        int          k;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  e;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;
    logic        req;
    logic [2:0]  en;
    logic [31:0] addr;

    always #5 clock = ~clock;

    riscv_imem_port_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
    riscv_imem_port_if #(.ADDR_W(32), .DATA_W(32)) if1 ();
    riscv_imem_port_if #(.ADDR_W(32), .DATA_W(32)) if2 ();

    assign if0.fetch_req  = req & en[0];
    assign if1.fetch_req  = req & en[1];
    assign if2.fetch_req  = req & en[2];
    assign if0.fetch_addr = addr;
    assign if1.fetch_addr = addr;
    assign if2.fetch_addr = addr;

    riscv_imem_port #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(0), .OOR_DATA(NOP)) u_ws0 (
        .clock(clock), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .fetch(if0));
    riscv_imem_port #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(3), .OOR_DATA(NOP)) u_ws3 (
        .clock(clock), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .fetch(if1));
    riscv_imem_port #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .WAIT_STATES(2), .OOR_DATA(NOP)) u_ws2 (
        .clock(clock), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .fetch(if2));

    logic        o_rdy [3];
    logic        o_vld [3];
    logic [31:0] o_dat [3];
    logic [1:0]  o_err [3];
    logic [31:0] o_cnt [3];

    assign o_rdy[0] = if0.fetch_ready;  assign o_rdy[1] = if1.fetch_ready;  assign o_rdy[2] = if2.fetch_ready;
    assign o_vld[0] = if0.fetch_valid;  assign o_vld[1] = if1.fetch_valid;  assign o_vld[2] = if2.fetch_valid;
    assign o_dat[0] = if0.fetch_data;   assign o_dat[1] = if1.fetch_data;   assign o_dat[2] = if2.fetch_data;
    assign o_err[0] = if0.fetch_err;    assign o_err[1] = if1.fetch_err;    assign o_err[2] = if2.fetch_err;
    assign o_cnt[0] = if0.fetch_count;  assign o_cnt[1] = if1.fetch_count;  assign o_cnt[2] = if2.fetch_count;

    // Model: an accepted request is due (valid) exactly WAIT_STATES+1 cycles later;
    // the port is busy strictly before its due cycle.
    int unsigned ws [3];
    longint      due [3];
    logic        m_rdy [3];
    logic        m_acc [3];
    logic [31:0] m_dat [3];
    logic [1:0]  m_err [3];
    logic [31:0] m_cnt [3];
    logic [31:0] mem [DEPTH];
    longint      cyc;
    int          tests;
    int          fails;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset(input int k);
        due[k]   = -1;
        m_dat[k] = '0;
        m_err[k] = '0;
        m_cnt[k] = '0;
    endfunction

    task automatic model_check();
        for (int k = 0; k < 3; k++) begin
            if (!reset_n) model_reset(k);
            m_rdy[k] = reset_n && !load_en && (cyc >= due[k]);
            chk($sformatf("ready%0d", k), 32'(o_rdy[k]), 32'(m_rdy[k]));
            chk($sformatf("valid%0d", k), 32'(o_vld[k]), 32'(reset_n && (cyc == due[k])));
            chk($sformatf("data%0d", k), o_dat[k], m_dat[k]);
            chk($sformatf("err%0d", k), 32'(o_err[k]), 32'(m_err[k]));
            chk($sformatf("count%0d", k), o_cnt[k], m_cnt[k]);
        end
    endtask

    task automatic model_advance();
        logic [1:0] e;
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 1'b0;
            if (reset_n) begin
                if (cyc == due[k]) m_cnt[k] = m_cnt[k] + 32'd1;
                if (req && en[k] && m_rdy[k]) begin
                    if (addr[1:0] != 2'b00)          e = 2'd1;
                    else if ((addr >> 2) >= DEPTH)   e = 2'd2;
                    else                             e = 2'd0;
                    m_err[k] = e;
                    m_dat[k] = (e == 2'd0) ? mem[addr[11:2]] : NOP;
                    due[k]   = cyc + longint'(ws[k]) + 1;
                    m_acc[k] = 1'b1;
                end
            end
        end
        if (load_en) mem[load_addr] = load_data;
    endtask

    task automatic tick();
        #1;
        model_check();
        model_advance();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input int k, input string name);
        int n = 0;
        while (o_vld[k] !== 1'b1 && n < BOUND) begin
            tick();
            n++;
        end
        tests++;
        if (n >= BOUND) begin
            fails++;
            $display("FAIL %s_timeout: no fetch_valid after %0d cycles, want fewer than %0d", name, n, BOUND);
        end
    endtask

    task automatic fetch_check(input int k, input logic [31:0] a, input logic [31:0] xd,
                               input logic [1:0] xe, input string name);
        int n = 0;
        en   = 3'(1 << k);
        req  = 1'b1;
        addr = a;
        do begin
            tick();
            n++;
        end while (!m_acc[k] && n < BOUND);
        req = 1'b0;
        en  = '0;
        tests++;
        if (!m_acc[k]) begin
            fails++;
            $display("FAIL %s_accept: not accepted after %0d cycles, want fewer than %0d", name, n, BOUND);
        end
        wait_valid(k, name);
        chk({name, "_data"}, o_dat[k], xd);
        chk({name, "_err"}, 32'(o_err[k]), 32'(xe));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl [10];
        logic [31:0] prog [4];
        int unsigned r;

        tests = 0;
        fails = 0;
        cyc   = 0;
        ws[0] = 0;
        ws[1] = 3;
        ws[2] = 2;
        prog  = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0000006F};

        tbl[0] = '{0, 32'h0000_0000, 32'h00500093, 2'd0};
        tbl[1] = '{0, 32'h0000_0004, 32'h00A00113, 2'd0};
        tbl[2] = '{1, 32'h0000_0008, 32'h002081B3, 2'd0};
        tbl[3] = '{1, 32'h0000_000C, 32'h0000006F, 2'd0};
        tbl[4] = '{2, 32'h0000_0006, NOP,          2'd1};
        tbl[5] = '{1, 32'h0000_1000, NOP,          2'd2};
        tbl[6] = '{0, 32'h0000_1002, NOP,          2'd1};
        tbl[7] = '{2, 32'h0000_0003, NOP,          2'd1};
        tbl[8] = '{2, 32'h0000_0FFC, 32'h12345678, 2'd0};
        tbl[9] = '{0, 32'hFFFF_FFFC, NOP,          2'd2};

        reset_n   = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        req       = 1'b0;
        en        = '0;
        addr      = '0;
        for (int k = 0; k < 3; k++) model_reset(k);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            load_en   = 1'b1;
            load_addr = 10'(i);
            if (i < 4)               load_data = prog[i];
            else if (i == DEPTH - 1) load_data = 32'h12345678;
            else                     load_data = $urandom;
            tick();
        end
        load_en = 1'b0;

        // Zero wait states: one fetch per cycle with request held high.
        en  = 3'b001;
        req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = 32'(i * 4);
            tick();
            chk($sformatf("b2b_valid%0d", i), 32'(o_vld[0]), 32'd1);
            chk($sformatf("b2b_data%0d", i), o_dat[0], prog[i]);
            chk($sformatf("b2b_err%0d", i), 32'(o_err[0]), 32'd0);
        end
        req = 1'b0;
        en  = '0;
        tick();
        chk("b2b_count", o_cnt[0], 32'd4);
        chk("b2b_idle", 32'(o_vld[0]), 32'd0);

        // Three wait states, then a new request taken in the RESP cycle.
        en   = 3'b010;
        req  = 1'b1;
        addr = 32'h4;
        tick();
        addr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ws3_ready_low%0d", i), 32'(o_rdy[1]), 32'd0);
            chk($sformatf("ws3_no_valid%0d", i), 32'(o_vld[1]), 32'd0);
            tick();
        end
        chk("ws3_valid", 32'(o_vld[1]), 32'd1);
        chk("ws3_data", o_dat[1], 32'h00A00113);
        chk("ws3_ready_in_resp", 32'(o_rdy[1]), 32'd1);
        tick();
        req = 1'b0;
        en  = '0;
        chk("ws3_b2b_busy", 32'(o_rdy[1]), 32'd0);
        wait_valid(1, "ws3_second");
        chk("ws3_second_data", o_dat[1], 32'h002081B3);
        tick();

        // Load to the same word while a fetch is in flight.
        en   = 3'b100;
        req  = 1'b1;
        addr = 32'h4;
        tick();
        req       = 1'b0;
        en        = '0;
        load_en   = 1'b1;
        load_addr = 10'd1;
        load_data = 32'hDEADBEEF;
        #1;
        chk("load_blocks_ready", 32'(o_rdy[0]), 32'd0);
        tick();
        load_en = 1'b0;
        wait_valid(2, "ld_inflight");
        chk("ld_inflight_data", o_dat[2], 32'h00A00113);
        tick();
        fetch_check(2, 32'h4, 32'hDEADBEEF, 2'd0, "ld_after");
        tick();
        load_en   = 1'b1;
        load_addr = 10'd1;
        load_data = prog[1];
        tick();
        load_en = 1'b0;

        for (int i = 0; i < 10; i++) begin
            fetch_check(tbl[i].k, tbl[i].a, tbl[i].d, tbl[i].e, $sformatf("vec%0d", i));
            tick();
        end

        // Reset in the middle of a wait: response is dropped, outputs clear at once.
        en   = 3'b010;
        req  = 1'b1;
        addr = 32'h8;
        tick();
        req = 1'b0;
        en  = '0;
        tick();
        reset_n = 1'b0;
        #1;
        chk("rst_ready", 32'(o_rdy[1]), 32'd0);
        chk("rst_valid", 32'(o_vld[1]), 32'd0);
        chk("rst_data", o_dat[1], 32'd0);
        chk("rst_err", 32'(o_err[1]), 32'd0);
        chk("rst_count", o_cnt[1], 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rst_no_valid%0d", i), 32'(o_vld[1]), 32'd0);
            tick();
        end
        fetch_check(1, 32'hC, 32'h0000006F, 2'd0, "post_rst");
        tick();
        chk("post_rst_count", o_cnt[1], 32'd1);

        // Counter wrap from a preloaded all-ones value.
        force u_ws0.count_q = 32'hFFFF_FFFF;
        #1;
        release u_ws0.count_q;
        m_cnt[0] = 32'hFFFF_FFFF;
        fetch_check(0, 32'h0, prog[0], 2'd0, "wrap");
        chk("wrap_pre", o_cnt[0], 32'hFFFF_FFFF);
        tick();
        chk("wrap_count", o_cnt[0], 32'd0);

        for (int i = 0; i < 3000; i++) begin
            r         = $urandom_range(99);
            reset_n   = ($urandom_range(299) != 0);
            load_en   = ($urandom_range(7) == 0);
            load_addr = 10'($urandom);
            load_data = $urandom;
            req       = 1'($urandom_range(1));
            en        = 3'($urandom);
            if (r < 80)      addr = 32'($urandom_range(DEPTH - 1)) << 2;
            else if (r < 90) addr = (32'($urandom_range(DEPTH - 1)) << 2) | 32'($urandom_range(3, 1));
            else             addr = ($urandom | 32'h0000_1000) & 32'hFFFF_FFFC;
            tick();
        end

        reset_n = 1'b1;
        load_en = 1'b0;
        req     = 1'b0;
        en      = '0;
        for (int i = 0; i < 6; i++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
